// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronizes and debounces phases A/B, then
// turns each legal Gray-code transition into a STEP pulse, a direction and a position.
module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  input  logic             B,
  input  logic             CLR_ERR,
  output logic             STEP,
  output logic             DIR,
  output logic [CNT_W-1:0] POS,
  output logic             ERR
);

  // state   | meaning
  // S_INIT  | settle timer running after reset; reference not yet valid
  // S_TRACK | compare filtered {A,B} against reference, emit STEP/ERR
  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  localparam logic [3:0]       FILT_CMP  = 4'(FILT_LEN);
  localparam logic [4:0]       INIT_WAIT = 5'(FILT_LEN + 2);
  localparam logic [CNT_W-1:0] POS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bit 1 carries phase A, bit 0 carries phase B throughout.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] filt_q, filt_d;
  logic [3:0] fcnt_q [2];
  logic [3:0] fcnt_d [2];

  state_t           state_q, state_d;
  logic [4:0]       timer_q, timer_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;
  logic [1:0]       delta;

  // Position of a {A,B} code along the up sequence 00,10,11,01.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // A full count means FILT_LEN consecutive opposing samples, so the level flips.
  always_comb begin
    sync1_d = {A, B};
    sync_d  = sync1_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = 4'd0;
      if (fcnt_q[i] == FILT_CMP) begin
        filt_d[i] = ~filt_q[i];
      end else if (sync_q[i] != filt_q[i]) begin
        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prev_d  = prev_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    err_d   = err_q;
    delta   = phase_idx(filt_q) - phase_idx(prev_q);
    if (CLR_ERR) begin
      err_d = 1'b0;
    end
    case (state_q)
      S_INIT: begin
        // The reference takes the level the filter settles to on this very edge.
        if (timer_q == 5'd0) begin
          prev_d  = filt_d;
          state_d = S_TRACK;
        end else begin
          timer_d = timer_q - 5'd1;
        end
      end
      S_TRACK: begin
        if (filt_q != prev_q) begin
          prev_d = filt_q;
          if (delta == 2'd2) begin
            err_d = 1'b1;
          end else begin
            step_d = 1'b1;
            dir_d  = (delta == 2'd1);
            pos_d  = (delta == 2'd1) ? pos_q + POS_ONE : pos_q - POS_ONE;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q   <= 2'b00;
      sync_q    <= 2'b00;
      filt_q    <= 2'b00;
      fcnt_q[0] <= 4'd0;
      fcnt_q[1] <= 4'd0;
      state_q   <= S_INIT;
      timer_q   <= INIT_WAIT;
      prev_q    <= 2'b00;
      step_q    <= 1'b0;
      dir_q     <= 1'b1;
      pos_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
      state_q   <= state_d;
      timer_q   <= timer_d;
      prev_q    <= prev_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
    end
  end

  assign STEP = step_q;
  assign DIR  = dir_q;
  assign POS  = pos_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random phase sequences,
// every cycle compared against a sample-window reference model.
module tb_quad_step_decoder;

  localparam int FL = 4;
  localparam int CW = 4;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          a_in, b_in, clr_err;
  logic          step, dir, err;
  logic [CW-1:0] pos;

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  quad_step_decoder #(.FILT_LEN(FL), .CNT_W(CW)) dut (
    .CLK(clk_sys), .RST(rst_n), .A(a_in), .B(b_in), .CLR_ERR(clr_err),
    .STEP(step), .DIR(dir), .POS(pos), .ERR(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a filtered level flips once the last FL synced samples,
  // all taken after its previous flip, oppose it.
  bit       m_valid = 1'b0;
  bit       m_s1 [2];
  bit       m_s2 [2];
  bit       m_f  [2];
  bit       m_hist [2][$];
  int       m_since [2];
  int       m_since_rst;
  bit       m_track;
  bit [1:0] m_prev;
  bit       m_step, m_dir, m_err;
  int       m_pos;

  function automatic int pidx(input bit [1:0] ab);
    bit [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int k = 0; k < 4; k++) if (up_seq[k] == ab) return k;
    return 0;
  endfunction

  always @(posedge clk_sys) begin
    bit [1:0] old_f, new_f;
    bit       in_bit [2];
    bit       samp, opposed;
    int       d;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_f[i] = 0; m_since[i] = 0;
        m_hist[i].delete();
      end
      m_since_rst = 0; m_track = 0; m_prev = 2'b00;
      m_step = 0; m_dir = 1; m_pos = 0; m_err = 0;
      m_valid = 1;
    end else if (m_valid) begin
      in_bit[1] = a_in; in_bit[0] = b_in;
      old_f = {m_f[1], m_f[0]};
      for (int i = 0; i < 2; i++) begin
        samp = m_s2[i];
        m_since[i]++;
        opposed = (m_hist[i].size() == FL) && (m_since[i] > FL);
        foreach (m_hist[i][k]) if (m_hist[i][k] == m_f[i]) opposed = 0;
        if (opposed) begin
          m_f[i] = ~m_f[i];
          m_since[i] = 0;
        end
        m_hist[i].push_back(samp);
        if (m_hist[i].size() > FL) void'(m_hist[i].pop_front());
        m_s2[i] = m_s1[i];
        m_s1[i] = in_bit[i];
      end
      new_f = {m_f[1], m_f[0]};
      m_step = 0;
      if (clr_err) m_err = 0;
      if (!m_track) begin
        m_since_rst++;
        if (m_since_rst == FL + 3) begin
          m_prev = new_f;
          m_track = 1;
        end
      end else if (old_f != m_prev) begin
        d = (pidx(old_f) - pidx(m_prev) + 4) % 4;
        if (d == 2) begin
          m_err = 1;
        end else begin
          m_step = 1;
          m_dir = (d == 1);
          m_pos = (m_pos + ((d == 1) ? 1 : -1) + (1 << CW)) % (1 << CW);
        end
        m_prev = old_f;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      chk("step", step, m_step);
      chk("dir", dir, m_dir);
      chk("pos", pos, m_pos);
      chk("err", err, m_err);
      if (step) n_steps++;
    end
  end

  task automatic hold(input bit a, input bit b, input int n);
    a_in = a; b_in = b;
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    bit [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    bit [1:0] nxt;
    int lat, base, cur;
    rst_n = 1'b0; a_in = 0; b_in = 0; clr_err = 0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;

    hold(0, 0, 20);
    chk("idle_step_count", n_steps, 0);
    chk("idle_pos", pos, 0);
    chk("idle_dir", dir, 1);
    chk("idle_err", err, 0);

    // Latency of the first up step, counted in sampling edges from A rising.
    a_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      if (step) begin
        lat = i;
        break;
      end
    end
    chk("first_step_latency", lat, FL + 4);
    hold(1, 0, 4);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("up4_steps", n_steps, 4);
    chk("up4_pos", pos, 4);
    chk("up4_dir", dir, 1);

    // Bring POS back to 0, then one down step wraps to 15.
    for (int k = 1; k <= 4; k++) hold(up_seq[(4 - k) % 4][1], up_seq[(4 - k) % 4][0], 10);
    chk("back_to_zero", pos, 0);
    hold(0, 1, 10);
    chk("down_wrap_pos", pos, 15);
    chk("down_wrap_dir", dir, 0);
    for (int k = 1; k <= 16; k++) hold(up_seq[(3 + k) % 4][1], up_seq[(3 + k) % 4][0], 10);
    chk("up16_pos", pos, 15);
    chk("up16_dir", dir, 1);
    hold(0, 0, 10);
    chk("up_wrap_pos", pos, 0);

    base = n_steps;
    hold(1, 0, FL - 1);
    hold(0, 0, 20);
    chk("short_glitch_steps", n_steps - base, 0);
    chk("short_glitch_pos", pos, 0);
    hold(1, 0, FL);
    hold(0, 0, 20);
    chk("long_glitch_steps", n_steps - base, 2);
    chk("long_glitch_pos", pos, 0);

    base = n_steps;
    hold(1, 1, 12);
    chk("illegal_err", err, 1);
    chk("illegal_pos", pos, 0);
    chk("illegal_steps", n_steps - base, 0);
    clr_err = 1'b1;
    @(negedge clk_sys);
    clr_err = 1'b0;
    chk("clr_err", err, 0);
    // Change lands at sampling edge N; detection is registered at edge N+FL+3.
    a_in = 0; b_in = 0;
    repeat (FL + 3) @(negedge clk_sys);
    clr_err = 1'b1;
    @(negedge clk_sys);
    clr_err = 1'b0;
    chk("set_beats_clear", err, 1);
    hold(0, 0, 10);

    for (int k = 1; k <= 9; k++) hold(up_seq[k % 4][1], up_seq[k % 4][0], 10);
    hold(0, 1, 12);
    chk("pre_reset_pos", pos, 9);
    chk("pre_reset_err", err, 1);
    a_in = 1; b_in = 1; rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    chk("rst_pos", pos, 0);
    chk("rst_err", err, 0);
    chk("rst_dir", dir, 1);
    chk("rst_step", step, 0);
    base = n_steps;
    hold(1, 1, 30);
    chk("adopt_steps", n_steps - base, 0);
    chk("adopt_err", err, 0);

    // Random phase walk: mostly legal neighbours, some illegal jumps and short glitches.
    cur = 2;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       nxt = up_seq[(cur + 2) % 4];
        1, 2:    nxt = 2'($urandom_range(0, 3));
        3, 4, 5: nxt = up_seq[(cur + 3) % 4];
        default: nxt = up_seq[(cur + 1) % 4];
      endcase
      cur = pidx(nxt);
      clr_err = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
      end
      hold(nxt[1], nxt[0], $urandom_range(1, 12));
    end
    clr_err = 1'b0;
    hold(a_in, b_in, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
